// File: rtl/key_matrix_scan.sv
// Parametrised ROWSxCOLS matrix-keypad scanner: debounces presses, locates the key by a row
// scan, and reports press/release pulses with optional auto-repeat.
module key_matrix_scan #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned KEY_W      = 4,
    parameter int unsigned DEB_CYC    = 500000,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned REPEAT_EN  = 0,
    parameter int unsigned RPT_DLY    = 12500000,
    parameter int unsigned RPT_PER    = 2500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  key_col,
    output logic [ROWS-1:0]  key_row,
    output logic [KEY_W-1:0] key_num,
    output logic             key_vld,
    output logic             key_rpt,
    output logic             key_rel,
    output logic             busy
);

    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DW      = $clog2(DEB_CYC + 1);
    localparam int unsigned SW      = $clog2(SETTLE_CYC + 1);
    localparam int unsigned RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int unsigned HW      = $clog2(RPT_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [DW-1:0] DEB_SAT  = DW'(DEB_CYC);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [HW-1:0] DLY_LAST = HW'(RPT_DLY - 1);
    localparam logic [HW-1:0] PER_LAST = HW'(RPT_PER - 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(RPT_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [COLS-1:0]  col_s1_q, col_s2_q;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [SW-1:0]    set_cnt_q, set_cnt_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic [KEY_W-1:0] key_num_q, key_num_d;
    logic             vld_q, vld_d;
    logic             rpt_q, rpt_d;
    logic             rel_q, rel_d;

    logic [CW-1:0]    low_col;
    logic             col_idle;
    logic             col_hit;
    logic [HW-1:0]    hold_lim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q    <= '1;
            col_s2_q    <= '1;
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            set_cnt_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            hold_cnt_q  <= '0;
            rpt_phase_q <= 1'b0;
            key_num_q   <= '0;
            vld_q       <= 1'b0;
            rpt_q       <= 1'b0;
            rel_q       <= 1'b0;
        end else begin
            col_s1_q    <= key_col;
            col_s2_q    <= col_s1_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            set_cnt_q   <= set_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hold_cnt_q  <= hold_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            key_num_q   <= key_num_d;
            vld_q       <= vld_d;
            rpt_q       <= rpt_d;
            rel_q       <= rel_d;
        end
    end

    // Lowest-index active column wins on a multi-column press.
    always_comb begin
        low_col = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!col_s2_q[i]) begin
                low_col = CW'(i);
            end
        end
    end

    assign col_idle = &col_s2_q;
    assign col_hit  = ~col_s2_q[col_q];
    assign hold_lim = rpt_phase_q ? PER_LAST : DLY_LAST;

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        set_cnt_d   = set_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        hold_cnt_d  = '0;
        rpt_phase_d = 1'b0;
        key_num_d   = key_num_q;
        vld_d       = 1'b0;
        rpt_d       = 1'b0;
        rel_d       = 1'b0;
        key_row     = '0;

        unique case (state_q)
            StIdle: begin
                if (col_idle) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = StScan;
                    deb_cnt_d = '0;
                    set_cnt_d = '0;
                    row_d     = '0;
                    col_d     = low_col;
                end else if (deb_cnt_q != DEB_SAT) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            StScan: begin
                key_row = ~(ROWS'(1) << row_q);
                if (set_cnt_q == SET_LAST) begin
                    set_cnt_d = '0;
                    if (col_hit) begin
                        key_num_d = KEY_W'(32'(row_q) * COLS + 32'(col_q));
                        vld_d     = 1'b1;
                        state_d   = StHold;
                        deb_cnt_d = '0;
                    end else if (row_q == ROW_LAST) begin
                        state_d   = StIdle;
                        deb_cnt_d = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end

            StHold: begin
                if (!col_idle) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    rel_d     = 1'b1;
                    state_d   = StIdle;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q != DEB_SAT) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end

                // A release decided this cycle suppresses any coincident repeat.
                if (REPEAT_EN != 0 && !rel_d && col_hit) begin
                    rpt_phase_d = rpt_phase_q;
                    if (hold_cnt_q == hold_lim) begin
                        vld_d       = 1'b1;
                        rpt_d       = 1'b1;
                        hold_cnt_d  = '0;
                        rpt_phase_d = 1'b1;
                    end else if (hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign key_num = key_num_q;
    assign key_vld = vld_q;
    assign key_rpt = rpt_q;
    assign key_rel = rel_q;
    assign busy    = (state_q != StIdle);

endmodule
